key_offset_lookup: RTL and testbench
====================================

# key_offset_lookup

Per-packet configuration front end for the key extractor. It queues each packet's VLAN ID, uses its low bits to index a 2^KEY_OFF_ADDR_WIDTH-entry table of key-offset and key-mask entries, and holds the result as `key_offset_valid` / `key_offset_w` / `key_mask_w`. The key extractor consumes that result. The table is written through a simple config port from the stage's control path.

## Interface
- `C_VLANID_WIDTH`, 12: VLAN ID width.
- `KEY_OFF`, 38: offset entry width, 6×3-bit container selects plus a 20-bit comparator op.
- `KEY_LEN`, 193: key mask width.
- `KEY_OFF_ADDR_WIDTH`, 4: table index width; index = `vlan_in[KEY_OFF_ADDR_WIDTH-1:0]`.
- `FIFO_DEPTH_LOG2`, 3: VLAN FIFO depth is 8.
- `STAGE_ID`, 0: informational only, no logic.

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: reset, asynchronous and active-high.
- `vlan_in`  in  C_VLANID_WIDTH: VLAN ID of the next packet.
- `vlan_valid_in`  in  1: VLAN ID present.
- `vlan_ready_out`  out  1: FIFO not full.
- `cfg_wr_en`  in  1: table write strobe.
- `cfg_wr_addr`  in  KEY_OFF_ADDR_WIDTH: table entry to write.
- `cfg_wr_key_off`  in  KEY_OFF: offset data to write.
- `cfg_wr_key_mask`  in  KEY_LEN: mask data to write.
- `key_offset_valid`  out  1: lookup result held.
- `key_offset_w`  out  KEY_OFF: offset result.
- `key_mask_w`  out  KEY_LEN: mask result.
- `key_offset_pop`  in  1: consumer took the result; driven as extractor-idle & `phv_valid_in` & `key_offset_valid`.
- `fifo_overflow`  out  1: sticky flag, VLAN ID offered while FIFO full.

## Operation
- Push: a VLAN ID is accepted when `vlan_valid_in & vlan_ready_out`.
  - `vlan_ready_out` = !full, computed from state at the start of the cycle.
  - A same-cycle pop does not free a slot for a push.
  - `vlan_valid_in` while full: the ID is dropped and `fifo_overflow` sets. It clears only on `rst`.
- Table: 2^KEY_OFF_ADDR_WIDTH registered entries of {off, mask}.
  - `cfg_wr_en` writes an entry at the clock edge.
  - Writes are accepted in every state.
- FSM states:
  - IDLE: if FIFO is non-empty, pop its head, latch the index, go to LOOKUP. Otherwise stay.
  - LOOKUP: register table[index] into `key_offset_w` / `key_mask_w`, set `key_offset_valid`, go to HOLD.
  - HOLD: outputs stable. On `key_offset_pop`, clear valid. Then, if FIFO is non-empty, pop and go to LOOKUP; else go to IDLE.
- Write/read collision: a `cfg_wr_en` to the same index during LOOKUP is bypassed, so the output takes the new write data.
- A write during HOLD does not alter the held output.
- `key_offset_pop` while `key_offset_valid`=0 is ignored.
- Results leave in VLAN arrival order; no reordering.

## Timing
- Reset values:
  - `key_offset_valid`=0, `key_offset_w`=0, `key_mask_w`=0.
  - `fifo_overflow`=0, FIFO empty, `vlan_ready_out`=1, state IDLE.
  - All table entries are 0.
- Latency: ID accepted at edge T → `key_offset_valid`=1 after edge T+2.
- Throughput: with the FIFO backlogged and pop asserted on the first valid cycle, one result every 2 cycles (HOLD→LOOKUP→HOLD). This matches the extractor's 2-cycle minimum per PHV.
- Falling edge of valid: pop at edge P → valid=0 after P. The next result is valid after P+1 at the earliest.
- Full boundary: with 8 entries held, `vlan_ready_out`=0. It rises the cycle after the FSM pops.
- Reset mid-operation: `rst` asserted in any state clears the FIFO, held output and table immediately (asynchronous). Packets in flight are lost.

## Structure
- Shared package `key_extract_pkg` holds:
  - `KEY_OFF`, `KEY_LEN`;
  - container-select and com_op field positions;
  - FSM state encodings.
- One sub-module, `key_vid_fifo`: parameterised synchronous FIFO with push, pop, full, empty and overflow. It contains no lookahead (no fall-through).
- The table and FSM live in the top module.

## Test plan
- Write entry 3 = {off 38'h1_2345_6789, mask all-ones}, then push VLAN 12'h013. Required:
  - valid after edge T+2;
  - `key_offset_w`=38'h1_2345_6789, `key_mask_w`=all-ones.
- Push 12'h005, 12'h006, 12'h007 back-to-back with pop asserted continuously:
  - three results in order, 2 cycles apart;
  - each equals table[5], table[6], table[7] respectively.
- Hold pop low and push 9 IDs:
  - `vlan_ready_out` falls after the 9th;
  - a 10th offer sets `fifo_overflow`=1;
  - the first 9 results drain correctly once pop resumes.
- In LOOKUP for index 2, write entry 2 = {off 38'hA, mask 0} in the same cycle:
  - output shows off 38'hA.
  - A later write to entry 2 during HOLD leaves the output unchanged.
- Pop pulse with valid=0 → no state change and no FIFO pop.
- Assert `rst` during HOLD with 4 IDs queued:
  - outputs and flag go to 0 immediately, FIFO empty, table zeroed;
  - a subsequent push returns off 0, mask 0.

Source files
------------

// File: rtl/key_extract_pkg.sv
// Shared definitions for the key extractor front end: entry widths, offset-entry field
// layout and the lookup FSM state encoding.
package key_extract_pkg;

  localparam int unsigned KEY_OFF = 38;
  localparam int unsigned KEY_LEN = 193;

  // Offset entry layout: comparator op in the low bits, six container selects above it.
  localparam int unsigned ComOpWidth = 20;
  localparam int unsigned ComOpLsb   = 0;
  localparam int unsigned CsWidth    = 3;
  localparam int unsigned CsNum      = 6;
  localparam int unsigned CsLsb      = ComOpLsb + ComOpWidth;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLookup = 2'd1,
    StHold   = 2'd2
  } lookup_state_e;

  // Container select number idx (0..CsNum-1) of an offset entry.
  function automatic logic [CsWidth-1:0] key_off_cs(input logic [KEY_OFF-1:0] off,
                                                    input int unsigned idx);
    return off[CsLsb + idx * CsWidth +: CsWidth];
  endfunction

  // Comparator op field of an offset entry.
  function automatic logic [ComOpWidth-1:0] key_off_com_op(input logic [KEY_OFF-1:0] off);
    return off[ComOpLsb +: ComOpWidth];
  endfunction

endpackage

// File: rtl/key_vid_fifo.sv
// Synchronous VLAN ID FIFO. Data pushed into an empty FIFO becomes visible at the head only
// after the write edge (no fall-through). Pushes while full are dropped and flagged.
module key_vid_fifo #(
  parameter int unsigned WIDTH      = 12,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  logic [WIDTH-1:0]      mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  overflow_q;
  logic                  push_ok, pop_ok;

  // Full/empty come from registered state, so a same-cycle pop never frees a slot for a push.
  assign full     = (count_q == (DEPTH_LOG2 + 1)'(Depth));
  assign empty    = (count_q == '0);
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign head     = mem_q[rd_ptr_q];
  assign overflow = overflow_q;

  // Storage array; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (push && full) begin
        overflow_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_offset_lookup.sv
// Per-packet key-offset/key-mask lookup. VLAN IDs are queued, each one's low bits index a
// register table, and the selected entry is held until the key extractor takes it.
module key_offset_lookup #(
  parameter int unsigned C_VLANID_WIDTH     = 12,
  parameter int unsigned KEY_OFF            = key_extract_pkg::KEY_OFF,
  parameter int unsigned KEY_LEN            = key_extract_pkg::KEY_LEN,
  parameter int unsigned KEY_OFF_ADDR_WIDTH = 4,
  parameter int unsigned FIFO_DEPTH_LOG2    = 3,
  parameter int unsigned STAGE_ID           = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [C_VLANID_WIDTH-1:0]     vlan_in,
  input  logic                          vlan_valid_in,
  output logic                          vlan_ready_out,
  input  logic                          cfg_wr_en,
  input  logic [KEY_OFF_ADDR_WIDTH-1:0] cfg_wr_addr,
  input  logic [KEY_OFF-1:0]            cfg_wr_key_off,
  input  logic [KEY_LEN-1:0]            cfg_wr_key_mask,
  output logic                          key_offset_valid,
  output logic [KEY_OFF-1:0]            key_offset_w,
  output logic [KEY_LEN-1:0]            key_mask_w,
  input  logic                          key_offset_pop,
  output logic                          fifo_overflow
);

  import key_extract_pkg::*;

  localparam int unsigned NumEntries = 2 ** KEY_OFF_ADDR_WIDTH;

  logic                          fifo_full, fifo_empty, fifo_pop;
  logic [C_VLANID_WIDTH-1:0]     fifo_head;

  lookup_state_e                 state_q, state_d;
  logic [KEY_OFF_ADDR_WIDTH-1:0] idx_q;

  logic [KEY_OFF-1:0]            tbl_off_q  [NumEntries];
  logic [KEY_LEN-1:0]            tbl_mask_q [NumEntries];

  logic [KEY_OFF-1:0]            off_q, rd_off;
  logic [KEY_LEN-1:0]            mask_q, rd_mask;
  logic                          valid_q;
  logic                          do_lookup, do_release, wr_hit;

  // Only the table index bits of the VLAN ID matter here.
  logic                          unused_vlan_hi;
  assign unused_vlan_hi = ^fifo_head[C_VLANID_WIDTH-1:KEY_OFF_ADDR_WIDTH];

  assign vlan_ready_out   = ~fifo_full;
  assign key_offset_valid = valid_q;
  assign key_offset_w     = off_q;
  assign key_mask_w       = mask_q;

  key_vid_fifo #(
    .WIDTH      (C_VLANID_WIDTH),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_vid_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (vlan_valid_in),
    .push_data (vlan_in),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .overflow  (fifo_overflow)
  );

  // Config writes land in the table at the clock edge, in any FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NumEntries); i++) begin
        tbl_off_q[i]  <= '0;
        tbl_mask_q[i] <= '0;
      end
    end else if (cfg_wr_en) begin
      tbl_off_q[cfg_wr_addr]  <= cfg_wr_key_off;
      tbl_mask_q[cfg_wr_addr] <= cfg_wr_key_mask;
    end
  end

  // Table read with write bypass so a same-index write during LOOKUP wins.
  always_comb begin
    wr_hit  = cfg_wr_en && (cfg_wr_addr == idx_q);
    rd_off  = wr_hit ? cfg_wr_key_off  : tbl_off_q[idx_q];
    rd_mask = wr_hit ? cfg_wr_key_mask : tbl_mask_q[idx_q];
  end

  // Next-state and control decode.
  always_comb begin
    state_d    = state_q;
    fifo_pop   = 1'b0;
    do_lookup  = 1'b0;
    do_release = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = StLookup;
        end
      end
      StLookup: begin
        do_lookup = 1'b1;
        state_d   = StHold;
      end
      StHold: begin
        if (key_offset_pop && valid_q) begin
          do_release = 1'b1;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = StLookup;
          end else begin
            state_d  = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the table index of the VLAN ID taken from the FIFO head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
    end else if (fifo_pop) begin
      idx_q <= fifo_head[KEY_OFF_ADDR_WIDTH-1:0];
    end
  end

  // Held lookup result; data stays put after release, only valid drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_q   <= '0;
      mask_q  <= '0;
      valid_q <= 1'b0;
    end else if (do_lookup) begin
      off_q   <= rd_off;
      mask_q  <= rd_mask;
      valid_q <= 1'b1;
    end else if (do_release) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_key_offset_lookup.sv
// Self-checking bench for key_offset_lookup: directed boundary scenarios plus a random
// push/pop phase scored against an in-order queue of expected table entries.
module tb_key_offset_lookup;

  localparam int unsigned VW = 12;
  localparam int unsigned KO = 38;
  localparam int unsigned KL = 193;
  localparam int unsigned AW = 4;
  localparam int unsigned NE = 16;

  typedef logic [255:0] cval_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [VW-1:0] vlan_in;
  logic          vlan_valid_in;
  logic          vlan_ready_out;
  logic          cfg_wr_en;
  logic [AW-1:0] cfg_wr_addr;
  logic [KO-1:0] cfg_wr_key_off;
  logic [KL-1:0] cfg_wr_key_mask;
  logic          key_offset_valid;
  logic [KO-1:0] key_offset_w;
  logic [KL-1:0] key_mask_w;
  logic          key_offset_pop;
  logic          fifo_overflow;

  // Reference state: table contents and in-order expected results.
  logic [KO-1:0] m_off  [NE];
  logic [KL-1:0] m_mask [NE];
  logic [KO-1:0] q_off  [$];
  logic [KL-1:0] q_mask [$];

  int n_checks = 0;
  int n_pass   = 0;

  key_offset_lookup #(
    .C_VLANID_WIDTH     (VW),
    .KEY_OFF            (KO),
    .KEY_LEN            (KL),
    .KEY_OFF_ADDR_WIDTH (AW),
    .FIFO_DEPTH_LOG2    (3),
    .STAGE_ID           (0)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .vlan_in          (vlan_in),
    .vlan_valid_in    (vlan_valid_in),
    .vlan_ready_out   (vlan_ready_out),
    .cfg_wr_en        (cfg_wr_en),
    .cfg_wr_addr      (cfg_wr_addr),
    .cfg_wr_key_off   (cfg_wr_key_off),
    .cfg_wr_key_mask  (cfg_wr_key_mask),
    .key_offset_valid (key_offset_valid),
    .key_offset_w     (key_offset_w),
    .key_mask_w       (key_mask_w),
    .key_offset_pop   (key_offset_pop),
    .fifo_overflow    (fifo_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input cval_t obs, input cval_t exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [KO-1:0] rand_off();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[KO-1:0];
  endfunction

  function automatic logic [KL-1:0] rand_mask();
    logic [223:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[KL-1:0];
  endfunction

  task automatic cfg_write(input logic [AW-1:0] a, input logic [KO-1:0] o,
                           input logic [KL-1:0] m);
    cfg_wr_en       = 1'b1;
    cfg_wr_addr     = a;
    cfg_wr_key_off  = o;
    cfg_wr_key_mask = m;
    tick();
    cfg_wr_en = 1'b0;
    m_off[a]  = o;
    m_mask[a] = m;
  endtask

  task automatic push_exp(input logic [VW-1:0] vid);
    q_off.push_back(m_off[vid[AW-1:0]]);
    q_mask.push_back(m_mask[vid[AW-1:0]]);
  endtask

  // Pop continuously, scoring every consumed result against the expected queue.
  task automatic drain(input int budget, input string tag);
    int n;
    n = 0;
    key_offset_pop = 1'b1;
    while (q_off.size() > 0 && n < budget) begin
      if (key_offset_valid) begin
        check({tag, "_off"}, cval_t'(key_offset_w), cval_t'(q_off[0]));
        check({tag, "_mask"}, cval_t'(key_mask_w), cval_t'(q_mask[0]));
        void'(q_off.pop_front());
        void'(q_mask.pop_front());
      end
      tick();
      n++;
    end
    key_offset_pop = 1'b0;
    check({tag, "_left"}, cval_t'(q_off.size()), cval_t'(0));
  endtask

  initial begin
    int            edges [$];
    logic [KO-1:0] c_off [$];
    logic [KL-1:0] c_mask [$];
    logic          do_push, do_pop;
    logic [VW-1:0] vid;

    rst             = 1'b1;
    vlan_in         = '0;
    vlan_valid_in   = 1'b0;
    cfg_wr_en       = 1'b0;
    cfg_wr_addr     = '0;
    cfg_wr_key_off  = '0;
    cfg_wr_key_mask = '0;
    key_offset_pop  = 1'b0;
    for (int i = 0; i < int'(NE); i++) begin
      m_off[i]  = '0;
      m_mask[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values.
    check("rst_valid", cval_t'(key_offset_valid), cval_t'(0));
    check("rst_off", cval_t'(key_offset_w), cval_t'(0));
    check("rst_mask", cval_t'(key_mask_w), cval_t'(0));
    check("rst_ovf", cval_t'(fifo_overflow), cval_t'(0));
    check("rst_ready", cval_t'(vlan_ready_out), cval_t'(1));

    // Single lookup and its latency.
    cfg_write(4'd3, 38'h1_2345_6789, {KL{1'b1}});
    vlan_in = 12'h013;
    vlan_valid_in = 1'b1;
    tick();
    vlan_valid_in = 1'b0;
    check("t1_valid_T", cval_t'(key_offset_valid), cval_t'(0));
    tick();
    check("t1_valid_T1", cval_t'(key_offset_valid), cval_t'(0));
    tick();
    check("t1_valid_T2", cval_t'(key_offset_valid), cval_t'(1));
    check("t1_off", cval_t'(key_offset_w), cval_t'(38'h1_2345_6789));
    check("t1_mask", cval_t'(key_mask_w), cval_t'({KL{1'b1}}));
    key_offset_pop = 1'b1;
    tick();
    key_offset_pop = 1'b0;
    check("t1_valid_fall", cval_t'(key_offset_valid), cval_t'(0));

    // Pop pulse in IDLE with nothing held.
    key_offset_pop = 1'b1;
    tick();
    key_offset_pop = 1'b0;
    check("t1_idle_pop_valid", cval_t'(key_offset_valid), cval_t'(0));
    check("t1_idle_pop_ready", cval_t'(vlan_ready_out), cval_t'(1));

    // Back-to-back throughput with pop held high.
    for (int a = 5; a <= 7; a++) cfg_write(AW'(a), rand_off(), rand_mask());
    key_offset_pop = 1'b1;
    for (int c = 0; c < 14; c++) begin
      vlan_valid_in = (c < 3);
      vlan_in = 12'(5 + c);
      tick();
      if (key_offset_valid) begin
        edges.push_back(c);
        c_off.push_back(key_offset_w);
        c_mask.push_back(key_mask_w);
      end
    end
    key_offset_pop = 1'b0;
    vlan_valid_in = 1'b0;
    check("t2_count", cval_t'(edges.size()), cval_t'(3));
    for (int k = 0; k < 3 && k < edges.size(); k++) begin
      check($sformatf("t2_edge%0d", k), cval_t'(edges[k]), cval_t'(2 + 2 * k));
      check($sformatf("t2_off%0d", k), cval_t'(c_off[k]), cval_t'(m_off[5 + k]));
      check($sformatf("t2_mask%0d", k), cval_t'(c_mask[k]), cval_t'(m_mask[5 + k]));
    end

    // Fill to the full boundary, overflow, then drain.
    for (int a = 0; a < int'(NE); a++) cfg_write(AW'(a), rand_off(), rand_mask());
    for (int i = 0; i < 9; i++) begin
      vid = 12'($urandom());
      check($sformatf("t3_ready%0d", i), cval_t'(vlan_ready_out), cval_t'(1));
      vlan_in = vid;
      vlan_valid_in = 1'b1;
      tick();
      push_exp(vid);
    end
    vlan_valid_in = 1'b0;
    check("t3_ready_full", cval_t'(vlan_ready_out), cval_t'(0));
    check("t3_ovf_pre", cval_t'(fifo_overflow), cval_t'(0));
    vlan_in = 12'hfff;
    vlan_valid_in = 1'b1;
    tick();
    vlan_valid_in = 1'b0;
    check("t3_ovf", cval_t'(fifo_overflow), cval_t'(1));
    check("t3_ready_still0", cval_t'(vlan_ready_out), cval_t'(0));
    check("t3_valid_held", cval_t'(key_offset_valid), cval_t'(1));
    check("t3_first_off", cval_t'(key_offset_w), cval_t'(q_off[0]));
    check("t3_first_mask", cval_t'(key_mask_w), cval_t'(q_mask[0]));
    void'(q_off.pop_front());
    void'(q_mask.pop_front());
    key_offset_pop = 1'b1;
    tick();
    check("t3_ready_rise", cval_t'(vlan_ready_out), cval_t'(1));
    drain(60, "t3");
    repeat (4) tick();
    check("t3_no_extra", cval_t'(key_offset_valid), cval_t'(0));
    check("t3_ovf_sticky", cval_t'(fifo_overflow), cval_t'(1));

    // Write to the looked-up index during LOOKUP bypasses; a write during HOLD does not.
    vlan_in = 12'h0a2;
    vlan_valid_in = 1'b1;
    tick();
    vlan_valid_in = 1'b0;
    tick();
    cfg_wr_en = 1'b1;
    cfg_wr_addr = 4'd2;
    cfg_wr_key_off = 38'ha;
    cfg_wr_key_mask = '0;
    tick();
    cfg_wr_en = 1'b0;
    m_off[2] = 38'ha;
    m_mask[2] = '0;
    check("t4_valid", cval_t'(key_offset_valid), cval_t'(1));
    check("t4_bypass_off", cval_t'(key_offset_w), cval_t'(38'ha));
    check("t4_bypass_mask", cval_t'(key_mask_w), cval_t'(0));
    cfg_write(4'd2, rand_off() | 38'h100, rand_mask());
    check("t4_hold_off", cval_t'(key_offset_w), cval_t'(38'ha));
    check("t4_hold_mask", cval_t'(key_mask_w), cval_t'(0));
    key_offset_pop = 1'b1;
    tick();
    key_offset_pop = 1'b0;

    // Pop while valid is low (during LOOKUP) must be ignored.
    vid = 12'($urandom());
    vlan_in = vid;
    vlan_valid_in = 1'b1;
    tick();
    push_exp(vid);
    vid = 12'($urandom());
    vlan_in = vid;
    tick();
    push_exp(vid);
    vlan_valid_in = 1'b0;
    key_offset_pop = 1'b1;
    tick();
    key_offset_pop = 1'b0;
    check("t5_valid", cval_t'(key_offset_valid), cval_t'(1));
    tick();
    check("t5_still_valid", cval_t'(key_offset_valid), cval_t'(1));
    check("t5_still_off", cval_t'(key_offset_w), cval_t'(q_off[0]));
    drain(20, "t5");

    // Asynchronous reset during HOLD with IDs queued.
    for (int i = 0; i < 5; i++) begin
      vlan_in = 12'($urandom());
      vlan_valid_in = 1'b1;
      tick();
    end
    vlan_valid_in = 1'b0;
    check("t6_valid_pre", cval_t'(key_offset_valid), cval_t'(1));
    check("t6_ovf_pre", cval_t'(fifo_overflow), cval_t'(1));
    #2 rst = 1'b1;
    #1;
    check("t6_valid", cval_t'(key_offset_valid), cval_t'(0));
    check("t6_off", cval_t'(key_offset_w), cval_t'(0));
    check("t6_mask", cval_t'(key_mask_w), cval_t'(0));
    check("t6_ovf", cval_t'(fifo_overflow), cval_t'(0));
    check("t6_ready", cval_t'(vlan_ready_out), cval_t'(1));
    tick();
    rst = 1'b0;
    for (int i = 0; i < int'(NE); i++) begin
      m_off[i]  = '0;
      m_mask[i] = '0;
    end
    q_off.delete();
    q_mask.delete();
    vlan_in = 12'h0b7;
    vlan_valid_in = 1'b1;
    tick();
    vlan_valid_in = 1'b0;
    tick();
    tick();
    check("t6_post_valid", cval_t'(key_offset_valid), cval_t'(1));
    check("t6_post_off", cval_t'(key_offset_w), cval_t'(0));
    check("t6_post_mask", cval_t'(key_mask_w), cval_t'(0));
    key_offset_pop = 1'b1;
    tick();
    key_offset_pop = 1'b0;
    repeat (4) tick();
    check("t6_fifo_empty", cval_t'(key_offset_valid), cval_t'(0));

    // Random traffic against the in-order reference.
    for (int a = 0; a < int'(NE); a++) cfg_write(AW'(a), rand_off(), rand_mask());
    for (int c = 0; c < 400; c++) begin
      do_push = ($urandom_range(0, 2) != 0) && vlan_ready_out;
      do_pop  = 1'($urandom_range(0, 1));
      vid     = 12'($urandom());
      vlan_valid_in  = do_push;
      vlan_in        = vid;
      key_offset_pop = do_pop;
      if (do_pop && key_offset_valid) begin
        if (q_off.size() == 0) begin
          check("rnd_spurious", cval_t'(key_offset_valid), cval_t'(0));
        end else begin
          check("rnd_off", cval_t'(key_offset_w), cval_t'(q_off[0]));
          check("rnd_mask", cval_t'(key_mask_w), cval_t'(q_mask[0]));
          void'(q_off.pop_front());
          void'(q_mask.pop_front());
        end
      end
      tick();
      if (do_push) push_exp(vid);
    end
    vlan_valid_in = 1'b0;
    drain(200, "rnd_drain");
    check("rnd_ovf", cval_t'(fifo_overflow), cval_t'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
